mem_arbiter_nch: RTL and testbench

Parametrised N-channel arbiter between cache-line clients and the single cacheline_adaptor port. It generalises the two-port instruction/data arbiter to NUM_CH clients and adds a selectable fixed-priority or round-robin policy. Each client request is registered before it reaches physical memory, and an explicit idle flag is exported for prefetch throttling.

---
 rtl/mem_arbiter_nch.sv | 120 ++++++++++++
 tb/tb_mem_arbiter_nch.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_nch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_nch : NUM_CH cache-line clients onto one memory port, fixed-priority or round-robin. Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter_nch #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*ADDR_W-1:0] req_address,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]        req_rdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp,
  output logic                     arbiter_idle
);

  localparam int IDX_W = $clog2(NUM_CH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_winner;
  logic [IDX_W-1:0]  w_win_hi;
  logic [IDX_W-1:0]  w_win_any;
  logic              w_hit_hi;
  logic [NUM_CH-1:0] w_valid;
  logic              w_take;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_op_write;

  assign w_valid = req_read | req_write;
  assign w_take  = (r_state == S_IDLE) && (|w_valid);

  // Lowest valid index above the pointer, else lowest valid overall: a wrapped scan from ptr+1.
  always_comb begin
    w_win_any = '0;
    w_win_hi  = '0;
    w_hit_hi  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_valid[i]) begin
        w_win_any = IDX_W'(i);
        if (i > int'(r_ptr)) begin
          w_win_hi = IDX_W'(i);
          w_hit_hi = 1'b1;
        end
      end
    end
    w_winner = (RR_MODE && w_hit_hi) ? w_win_hi : w_win_any;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (|w_valid) w_next_state = S_BUSY;
      S_BUSY:  if (pmem_resp) w_next_state = S_GAP;
      S_GAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= '0;
      r_ptr      <= IDX_W'(NUM_CH - 1);
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op_write <= 1'b0;
    end else if (w_take) begin
      r_grant    <= w_winner;
      if (RR_MODE) r_ptr <= w_winner;
      r_addr     <= req_address[int'(w_winner)*ADDR_W +: ADDR_W];
      r_wdata    <= req_wdata[int'(w_winner)*LINE_W +: LINE_W];
      // Read and write together on one channel resolves to a write.
      r_op_write <= req_write[w_winner];
    end
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    req_resp   = '0;
    if (r_state == S_BUSY) begin
      pmem_read  = ~r_op_write;
      pmem_write = r_op_write;
      if (pmem_resp) req_resp[r_grant] = 1'b1;
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign req_rdata    = pmem_rdata;
  assign arbiter_idle = (r_state == S_IDLE) && !(|w_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_nch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter_nch : scoreboard bench driving a fixed-priority and a round-robin arbiter. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter_nch;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef struct {
    int                ch;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  bit [1:0] done   = '0;

  task automatic chk(input bit ok, input string name,
                     input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Instance 0 is fixed priority, instance 1 is round-robin.
  for (genvar m = 0; m < 2; m++) begin : g_inst
    localparam bit RR = (m == 1);

    logic                     reset_n;
    logic [NUM_CH*ADDR_W-1:0] req_address;
    logic [NUM_CH-1:0]        req_read;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH*LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0]        req_rdata;
    logic [NUM_CH-1:0]        req_resp;
    logic [ADDR_W-1:0]        pmem_address;
    logic [LINE_W-1:0]        pmem_wdata;
    logic                     pmem_read;
    logic                     pmem_write;
    logic [LINE_W-1:0]        pmem_rdata;
    logic                     pmem_resp;
    logic                     arbiter_idle;

    mem_arbiter_nch #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W),
      .RR_MODE(RR)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_address (req_address),
      .req_read    (req_read),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_rdata   (req_rdata),
      .req_resp    (req_resp),
      .pmem_address(pmem_address),
      .pmem_wdata  (pmem_wdata),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_rdata  (pmem_rdata),
      .pmem_resp   (pmem_resp),
      .arbiter_idle(arbiter_idle)
    );

    txn_t              sb[$];
    txn_t              cq[NUM_CH][$];
    int                model_ptr   = NUM_CH - 1;
    bit                mon_en      = 1'b0;
    bit                mem_en      = 1'b0;
    bit                use_a5      = 1'b0;
    bit                stray_req   = 1'b0;
    int                fixed_delay = -1;
    logic [LINE_W-1:0] mem_line;

    function automatic string nm(input string s);
      return $sformatf("m%0d_%s", m, s);
    endfunction

    // op: 0 = read, 1 = write, 2 = read and write together
    task automatic add(input int c, input int op, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d);
      txn_t t;
      t.ch    = c;
      t.rd    = (op != 1);
      t.wr    = (op != 0);
      t.addr  = a;
      t.wdata = d;
      cq[c].push_back(t);
    endtask

    // Reference: serve the clients' pending queues one transaction at a time by policy.
    task automatic model_round();
      txn_t q[NUM_CH][$];
      int   w;
      bit   more;
      for (int c = 0; c < NUM_CH; c++) q[c] = cq[c];
      more = 1'b1;
      while (more) begin
        w = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
          int c;
          c = RR ? (model_ptr + k) % NUM_CH : k - 1;
          if (w < 0 && q[c].size() > 0) w = c;
        end
        if (w < 0) begin
          more = 1'b0;
        end else begin
          sb.push_back(q[w][0]);
          q[w].delete(0);
          if (RR) model_ptr = w;
        end
      end
    endtask

    task automatic drive_head(input int c);
      if (cq[c].size() > 0) begin
        req_read[c]                     = cq[c][0].rd;
        req_write[c]                    = cq[c][0].wr;
        req_address[c*ADDR_W +: ADDR_W] = cq[c][0].addr;
        req_wdata[c*LINE_W +: LINE_W]   = cq[c][0].wdata;
      end else begin
        req_read[c]  = 1'b0;
        req_write[c] = 1'b0;
      end
    endtask

    task automatic run_round();
      logic [NUM_CH-1:0] r;
      int                budget;
      bit                pending;
      model_round();
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) drive_head(c);
      budget  = 0;
      pending = 1'b1;
      while (pending && budget < 2000) begin
        @(negedge clk);
        r = req_resp;
        @(posedge clk); #1;
        pending = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (r[c] && cq[c].size() > 0) begin
            cq[c].delete(0);
            drive_head(c);
          end
          if (cq[c].size() > 0) pending = 1'b1;
        end
        budget++;
      end
      chk(!pending, nm("round_done"), pending, 0);
      if (pending) begin
        for (int c = 0; c < NUM_CH; c++) begin
          cq[c].delete();
          drive_head(c);
        end
      end
      repeat (3) @(negedge clk);
      chk(sb.size() == 0, nm("sb_drain"), sb.size(), 0);
      sb.delete();
    endtask

    // Memory model: answers each strobe after a delay, or once on request with no strobe.
    initial begin : p_mem
      int cnt;
      cnt        = -1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      mem_line   = '0;
      forever begin
        @(posedge clk); #1;
        if (pmem_resp) begin
          pmem_resp = 1'b0;
          cnt       = -1;
        end else if (stray_req) begin
          stray_req = 1'b0;
          pmem_resp = 1'b1;
        end else if (mem_en && (pmem_read || pmem_write)) begin
          if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
          if (cnt == 0) begin
            mem_line   = use_a5 ? {32{8'hA5}} : rand_line();
            pmem_rdata = mem_line;
            pmem_resp  = 1'b1;
            cnt        = -1;
          end else begin
            cnt--;
          end
        end
      end
    end

    initial begin : p_mon
      txn_t cur;
      bit   have, on, prev_on, prev_req, prev_valid;
      int   since, prev_since;
      have = 0; prev_on = 0; prev_req = 0; prev_valid = 0;
      since = 99; prev_since = 99;
      cur.ch = 0;
      forever begin
        @(negedge clk);
        if (!mon_en) begin
          prev_valid = 1'b0;
          since      = 99;
          have       = 1'b0;
        end else begin
          if (since < 99) since++;
          on = pmem_read | pmem_write;
          if (prev_valid && !prev_on && prev_since != 1)
            chk(on == prev_req, nm("latency"), on, prev_req);
          if (since == 1)
            chk(!on && req_resp == 0, nm("gap"), {on, req_resp}, 0);
          if (!on) begin
            chk(req_resp == 0, nm("resp_idle"), req_resp, 0);
            if (since != 1)
              chk(arbiter_idle == !(|(req_read | req_write)), nm("idle_flag"),
                  arbiter_idle, !(|(req_read | req_write)));
          end
          if (on && !prev_on) begin
            chk(sb.size() > 0, nm("grant_expected"), sb.size(), 1);
            have = (sb.size() > 0);
            if (have) begin
              cur = sb.pop_front();
              chk(pmem_write == cur.wr && pmem_read == !cur.wr, nm("op"),
                  {pmem_read, pmem_write}, {!cur.wr, cur.wr});
              chk(pmem_address == cur.addr, nm("addr"), pmem_address, cur.addr);
              if (cur.wr) chk(pmem_wdata == cur.wdata, nm("wdata"), pmem_wdata, cur.wdata);
            end
          end
          if (req_resp != 0) begin
            chk(have && req_resp == (NUM_CH'(1) << cur.ch), nm("resp_onehot"),
                req_resp, NUM_CH'(1) << cur.ch);
            chk(req_rdata == mem_line, nm("rdata"), req_rdata, mem_line);
            since = 0;
            have  = 1'b0;
          end
          prev_on    = on;
          prev_req   = |(req_read | req_write);
          prev_since = since;
          prev_valid = 1'b1;
        end
      end
    end

    initial begin : p_drv
      reset_n     = 1'b0;
      req_read    = '1;
      req_write   = '0;
      req_address = '0;
      req_wdata   = '0;
      repeat (3) @(negedge clk);
      chk(!pmem_read && !pmem_write, nm("rst_strobe"), {pmem_read, pmem_write}, 0);
      chk(req_resp == 0, nm("rst_resp"), req_resp, 0);
      chk(arbiter_idle == 1'b0, nm("rst_idle"), arbiter_idle, 0);
      chk(pmem_address == 0, nm("rst_addr"), pmem_address, 0);
      req_read = '0;
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      mem_en  = 1'b1;

      // All clients contend; ch0 comes back for a second line.
      add(0, 0, 32'h0000_0100, rand_line());
      add(0, 1, 32'h0000_0140, rand_line());
      add(1, 0, 32'h0000_0200, rand_line());
      add(2, 1, 32'h0000_0300, rand_line());
      add(3, 0, 32'h0000_0400, rand_line());
      run_round();

      // Single read with a slow memory and a known line.
      fixed_delay = 5;
      use_a5      = 1'b1;
      add(1, 0, 32'h0000_1240, '0);
      run_round();
      fixed_delay = -1;
      use_a5      = 1'b0;

      // ch0 keeps requesting against ch2.
      for (int i = 0; i < 3; i++) add(0, 0, 32'h0000_0800 + i * 32'h40, rand_line());
      add(2, 0, 32'h0000_0A00, rand_line());
      run_round();

      // Read and write raised together on ch0.
      add(0, 2, 32'h0000_0080, {8{32'h1234_5678}});
      run_round();

      for (int r = 0; r < 25; r++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          int n;
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) add(c, int'($urandom_range(0, 2)), $urandom, rand_line());
        end
        run_round();
      end

      // Reset two cycles into a read, then a stray memory response.
      mon_en = 1'b0;
      mem_en = 1'b0;
      @(posedge clk); #1;
      req_read[1]                  = 1'b1;
      req_address[ADDR_W +: ADDR_W] = 32'h0000_2000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk(pmem_read == 1'b1, nm("busy_pre_rst"), pmem_read, 1);
      reset_n = 1'b0;
      #1;
      chk(!pmem_read && !pmem_write && req_resp == 0, nm("async_rst"),
          {pmem_read, pmem_write, req_resp}, 0);
      req_read = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      stray_req = 1'b1;
      @(posedge clk); #1;
      chk(pmem_resp == 1'b1, nm("stray_driven"), pmem_resp, 1);
      chk(req_resp == 0 && !pmem_read && !pmem_write, nm("stray_ignored"),
          {req_resp, pmem_read, pmem_write}, 0);
      chk(arbiter_idle == 1'b1, nm("stray_idle"), arbiter_idle, 1);
      @(negedge clk);
      chk(req_resp == 0 && !pmem_read && !pmem_write, nm("post_stray"),
          {req_resp, pmem_read, pmem_write}, 0);
      done[m] = 1'b1;
    end
  end

  initial begin : p_top
    int cyc;
    cyc = 0;
    while (done != 2'b11 && cyc < 50000) begin
      @(negedge clk);
      cyc++;
    end
    chk(done == 2'b11, "all_done", done, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
